// File: rtl/data_memory_responder.sv
// Wait-state memory responder for the core's load/store and fetch port.
// One request in flight; byte-lane stores with alignment and range checks.
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req__valid,
  output logic                  req__ready,
  input  logic                  req__write,
  input  logic [ADDR_WIDTH-1:0] req__address,
  input  logic [31:0]           req__write_data,
  input  logic [3:0]            req__byte_enable,
  output logic                  rsp__valid,
  output logic [31:0]           rsp__read_data,
  output logic                  rsp__error
);

  localparam int unsigned IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH =
    ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data;
    logic [3:0]            be;
  } req_t;

  logic [31:0] M [0:DEPTH_WORDS-1];

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t lat_q, cur, acc;

  logic accept, do_access;
  logic [ADDR_WIDTH-1:0] offset, word;
  logic [IW-1:0] idx;
  logic [1:0] a;
  logic in_range, st_ok, ok;

  assign req__ready = (state_q == ST_IDLE) && reset;
  assign accept     = req__valid && req__ready;

  assign cur = '{
    write:   req__write,
    address: req__address,
    data:    req__write_data,
    be:      req__byte_enable
  };

  // Zero wait states access with live inputs at the accept edge.
  assign acc = (state_q == ST_IDLE) ? cur : lat_q;

  assign do_access = reset && (
    (accept && (WS == 4'd0)) ||
    (state_q == ST_WAIT && cnt_q == 4'd1));

  assign offset   = acc.address - BASE;
  assign word     = offset >> 2;
  assign idx      = word[IW-1:0];
  assign a        = acc.address[1:0];
  assign in_range = (acc.address >= BASE) && (word < DEPTH);

  assign st_ok =
    (acc.be == 4'b1111 && a == 2'd0) ||
    (acc.be == 4'b0011 && a == 2'd0) ||
    (acc.be == 4'b1100 && a == 2'd2) ||
    (acc.be == (4'b0001 << a));

  assign ok = in_range && (acc.write ? st_ok : (a == 2'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WS == 4'd0) begin
            state_d = ST_RESPOND;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESPOND;
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      lat_q          <= '0;
      rsp__valid     <= 1'b0;
      rsp__read_data <= '0;
      rsp__error     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) lat_q <= cur;
      if (do_access) begin
        rsp__valid     <= 1'b1;
        rsp__error     <= !ok;
        rsp__read_data <= (ok && !acc.write) ? M[idx] : '0;
      end else if (state_q == ST_RESPOND) begin
        rsp__valid     <= 1'b0;
        rsp__read_data <= '0;
        rsp__error     <= 1'b0;
      end
    end
  end

  // Storage is not reset so benches can preload it.
  always_ff @(posedge clk) begin
    if (do_access && ok && acc.write) begin
      for (int i = 0; i < 4; i++) begin
        if (acc.be[i]) M[idx][8*i +: 8] <= acc.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder at one and three wait states.
// Expected values are hand computed from the access rules.
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        reset1, v1, w1, rdy1, rv1, re1;
  logic [31:0] a1, d1, rd1;
  logic [3:0]  be1;

  logic        reset3, v3, w3, rdy3, rv3, re3;
  logic [31:0] a3, d3, rd3;
  logic [3:0]  be3;

  data_memory_responder #(
    .ADDR_WIDTH(32), .DEPTH_WORDS(1024),
    .BASE_ADDR(0), .WAIT_STATES(1)
  ) u_dut1 (
    .clk(clk), .reset(reset1),
    .req__valid(v1), .req__ready(rdy1),
    .req__write(w1), .req__address(a1),
    .req__write_data(d1), .req__byte_enable(be1),
    .rsp__valid(rv1), .rsp__read_data(rd1),
    .rsp__error(re1)
  );

  data_memory_responder #(
    .ADDR_WIDTH(32), .DEPTH_WORDS(1024),
    .BASE_ADDR(0), .WAIT_STATES(3)
  ) u_dut3 (
    .clk(clk), .reset(reset3),
    .req__valid(v3), .req__ready(rdy3),
    .req__write(w3), .req__address(a3),
    .req__write_data(d3), .req__byte_enable(be3),
    .rsp__valid(rv3), .rsp__read_data(rd3),
    .rsp__error(re3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on dut1; returns data, error and edges to response.
  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output logic [31:0] rd, output logic err,
                        output int lat);
    chk("ready_before_req", {31'd0, rdy1}, 32'd1);
    v1 = 1'b1; w1 = wr; a1 = addr; d1 = data; be1 = be;
    tick();
    v1 = 1'b0;
    lat = 0;
    while (!rv1 && lat < 20) begin
      tick();
      lat++;
    end
    if (!rv1) chk("rsp_timeout", 32'd0, 32'd1);
    rd  = rd1;
    err = re1;
    tick();
    chk("rsp_one_cycle", {31'd0, rv1}, 32'd0);
    chk("rsp_data_cleared", rd1, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, n;
  logic        prev_rdy;

  initial begin
    reset1 = 1'b0; v1 = 0; w1 = 0; a1 = 0; d1 = 0; be1 = 0;
    reset3 = 1'b0; v3 = 0; w3 = 0; a3 = 0; d3 = 0; be3 = 0;
    tick(); tick(); tick();
    chk("reset_ready", {31'd0, rdy1}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rv1}, 32'd0);
    chk("reset_rsp_data", rd1, 32'd0);
    chk("reset_rsp_error", {31'd0, re1}, 32'd0);
    reset1 = 1'b1;
    reset3 = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, rdy1}, 32'd1);

    do_req(1'b1, 32'd44, 32'h0000_0100, 4'b1111, rd, err, lat);
    chk("sw44_latency", lat, 32'd1);
    chk("sw44_error", {31'd0, err}, 32'd0);
    chk("sw44_data", rd, 32'd0);
    chk("sw44_mem", u_dut1.M[11], 32'h0000_0100);

    u_dut1.M[12] = 32'hcafe_babe;
    do_req(1'b0, 32'd48, 32'hffff_ffff, 4'b0000, rd, err, lat);
    chk("lw48_data", rd, 32'hcafe_babe);
    chk("lw48_error", {31'd0, err}, 32'd0);

    u_dut1.M[11] = 32'hdead_beef;
    do_req(1'b1, 32'd46, 32'h00ab_0000, 4'b0100, rd, err, lat);
    chk("sb46_error", {31'd0, err}, 32'd0);
    chk("sb46_mem", u_dut1.M[11], 32'hdeab_beef);

    do_req(1'b1, 32'd46, 32'h1234_0000, 4'b1100, rd, err, lat);
    chk("sh46_error", {31'd0, err}, 32'd0);
    chk("sh46_mem", u_dut1.M[11], 32'h1234_beef);

    do_req(1'b1, 32'd45, 32'hffff_ffff, 4'b1111, rd, err, lat);
    chk("sw45_error", {31'd0, err}, 32'd1);
    chk("sw45_mem", u_dut1.M[11], 32'h1234_beef);

    do_req(1'b0, 32'd4096, 32'd0, 4'b0000, rd, err, lat);
    chk("lw4096_error", {31'd0, err}, 32'd1);
    chk("lw4096_data", rd, 32'd0);

    do_req(1'b0, 32'd50, 32'd0, 4'b0000, rd, err, lat);
    chk("lw50_misaligned", {31'd0, err}, 32'd1);

    do_req(1'b1, 32'd44, 32'hffff_ffff, 4'b0000, rd, err, lat);
    chk("be0000_error", {31'd0, err}, 32'd1);
    chk("be0000_mem", u_dut1.M[11], 32'h1234_beef);

    do_req(1'b1, 32'd44, 32'hffff_ffff, 4'b0110, rd, err, lat);
    chk("be0110_error", {31'd0, err}, 32'd1);

    do_req(1'b1, 32'd47, 32'h7700_0000, 4'b1000, rd, err, lat);
    chk("sb47_error", {31'd0, err}, 32'd0);
    chk("sb47_mem", u_dut1.M[11], 32'h7734_beef);

    do_req(1'b1, 32'd4092, 32'h0bad_f00d, 4'b1111, rd, err, lat);
    chk("sw_last_error", {31'd0, err}, 32'd0);
    chk("sw_last_mem", u_dut1.M[1023], 32'h0bad_f00d);

    // Back-to-back stores with valid held high.
    v1 = 1'b1; w1 = 1'b1; a1 = 32'd44;
    d1 = 32'h1111_1111; be1 = 4'b1111;
    tick();
    a1 = 32'd48; d1 = 32'h2222_2222;
    chk("b2b_ready_wait", {31'd0, rdy1}, 32'd0);
    n = 0;
    prev_rdy = rdy1;
    while (!prev_rdy && n < 10) begin
      prev_rdy = rdy1;
      tick();
      n++;
      if (n == 1) chk("b2b_ready_respond", {31'd0, rdy1}, 32'd0);
    end
    v1 = 1'b0;
    chk("b2b_accept_spacing", n, 32'd3);
    tick(); tick(); tick();
    chk("b2b_mem44", u_dut1.M[11], 32'h1111_1111);
    chk("b2b_mem48", u_dut1.M[12], 32'h2222_2222);

    // Three wait states: normal load latency, then reset during WAIT.
    u_dut3.M[11] = 32'h5555_5555;
    chk("ws3_ready", {31'd0, rdy3}, 32'd1);
    v3 = 1'b1; w3 = 1'b0; a3 = 32'd44; be3 = 4'b0000;
    tick();
    v3 = 1'b0;
    lat = 0;
    while (!rv3 && lat < 20) begin
      tick();
      lat++;
    end
    chk("ws3_latency", lat, 32'd3);
    chk("ws3_load", rd3, 32'h5555_5555);
    tick();

    v3 = 1'b1; w3 = 1'b1; a3 = 32'd44;
    d3 = 32'h9999_9999; be3 = 4'b1111;
    tick();
    v3 = 1'b0;
    tick();
    reset3 = 1'b0;
    #1;
    chk("ws3_ready_in_reset", {31'd0, rdy3}, 32'd0);
    tick();
    reset3 = 1'b1;
    #1;
    chk("ws3_ready_after_reset", {31'd0, rdy3}, 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (rv3) n++;
      tick();
    end
    chk("ws3_no_response", n, 32'd0);
    chk("ws3_mem_unchanged", u_dut3.M[11], 32'h5555_5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
